// File: rtl/trip_pkg.sv
// Shared types and default parameters for the trip status generator.
// State encoding and default thresholds live here so the bench and RTL agree.
package trip_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVING = 2'd1,
        S_REFUEL  = 2'd2,
        S_DONE    = 2'd3
    } trip_state_e;

    localparam logic [7:0] FUEL_CAP_DEF    = 8'd255;
    localparam int         BURN_PERIOD_DEF = 4;
    localparam logic [7:0] TEMP_HI_DEF     = 8'd90;
    localparam logic [7:0] TEMP_LO_DEF     = 8'd70;

endpackage

// File: rtl/temp_hysteresis.sv
// Hysteretic overheat flag: set at or above TEMP_HI, clear at or below TEMP_LO.
module temp_hysteresis
    import trip_pkg::*;
#(
    parameter logic [7:0] TEMP_HI = TEMP_HI_DEF,
    parameter logic [7:0] TEMP_LO = TEMP_LO_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cpu_temp,
    output logic       cpu_overheated
);

    logic hot_q;
    logic hot_d;

    always_comb begin
        hot_d = hot_q;
        if (cpu_temp >= TEMP_HI) begin
            hot_d = 1'b1;
        end else if (cpu_temp <= TEMP_LO) begin
            hot_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hot_q <= 1'b0;
        end else begin
            hot_q <= hot_d;
        end
    end

    assign cpu_overheated = hot_q;

endmodule

// File: rtl/trip_status_gen.sv
// Trip FSM with fuel burn accounting, refuel handshake and overheat flag.
// Optional TRIP_ODOMETER_EN adds a free-running moving-cycle odometer output.
module trip_status_gen
    import trip_pkg::*;
#(
    parameter logic [7:0] FUEL_CAP    = FUEL_CAP_DEF,
    parameter int         BURN_PERIOD = BURN_PERIOD_DEF,
    parameter logic [7:0] TEMP_HI     = TEMP_HI_DEF,
    parameter logic [7:0] TEMP_LO     = TEMP_LO_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] trip_dist,
    input  logic        keep_driving,
    input  logic        shut_off_computer,
    input  logic [7:0]  cpu_temp,
    input  logic        refuel_ack,
    output logic        arrived,
    output logic        gas_tank_empty,
    output logic        cpu_overheated,
    output logic        refuel_req
`ifdef TRIP_ODOMETER_EN
    ,
    output logic [31:0] odometer
`endif
);

    localparam logic [7:0] BURN_LAST = 8'(BURN_PERIOD - 1);

    trip_state_e state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [7:0]  fuel_q, fuel_d;
    logic [7:0]  burn_q, burn_d;
    logic        arrived_q;
    logic        refuel_q;
    logic        moving;

    // Remaining must be nonzero too, so the distance count never underflows.
    assign moving = (state_q == S_DRIVING) && keep_driving
                 && !shut_off_computer && (fuel_q != 8'd0)
                 && (remaining_q != 16'd0);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        fuel_d      = fuel_q;
        burn_d      = burn_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    remaining_d = trip_dist;
                    state_d = (trip_dist == 16'd0) ? S_DONE : S_DRIVING;
                end
            end
            S_DRIVING: begin
                if (remaining_q == 16'd0) begin
                    state_d = S_DONE;
                end else if (fuel_q == 8'd0) begin
                    state_d = S_REFUEL;
                end else if (moving) begin
                    remaining_d = remaining_q - 16'd1;
                    if (burn_q == BURN_LAST) begin
                        burn_d = 8'd0;
                        fuel_d = fuel_q - 8'd1;
                    end else begin
                        burn_d = burn_q + 8'd1;
                    end
                end
            end
            S_REFUEL: begin
                if (refuel_ack) begin
                    fuel_d  = FUEL_CAP;
                    burn_d  = 8'd0;
                    state_d = S_DRIVING;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= 16'd0;
            fuel_q      <= FUEL_CAP;
            burn_q      <= 8'd0;
            arrived_q   <= 1'b0;
            refuel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            fuel_q      <= fuel_d;
            burn_q      <= burn_d;
            arrived_q   <= (state_d == S_DONE);
            refuel_q    <= (state_d == S_REFUEL);
        end
    end

    assign arrived        = arrived_q;
    assign refuel_req     = refuel_q;
    assign gas_tank_empty = (fuel_q == 8'd0);

`ifdef TRIP_ODOMETER_EN
    logic [31:0] odo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            odo_q <= 32'd0;
        end else if (moving) begin
            odo_q <= odo_q + 32'd1;
        end
    end

    assign odometer = odo_q;
`endif

    temp_hysteresis #(
        .TEMP_HI(TEMP_HI),
        .TEMP_LO(TEMP_LO)
    ) u_temp (
        .clk           (clk),
        .reset         (reset),
        .cpu_temp      (cpu_temp),
        .cpu_overheated(cpu_overheated)
    );

endmodule

// File: tb/tb_trip_status_gen.sv
// Directed bench: default, small-tank and exact-fuel instances share stimulus.
module tb_trip_status_gen;
    import trip_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] trip_dist;
    logic        keep_driving;
    logic        shut_off_computer;
    logic [7:0]  cpu_temp;
    logic        refuel_ack;

    logic a_arr, a_empty, a_hot, a_req;
    logic b_arr, b_empty, b_hot, b_req;
    logic c_arr, c_empty, c_hot, c_req;
`ifdef TRIP_ODOMETER_EN
    logic [31:0] a_odo, b_odo, c_odo;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    trip_status_gen a (
        .clk(clk), .reset(reset), .start(start), .trip_dist(trip_dist),
        .keep_driving(keep_driving), .shut_off_computer(shut_off_computer),
        .cpu_temp(cpu_temp), .refuel_ack(refuel_ack),
        .arrived(a_arr), .gas_tank_empty(a_empty),
        .cpu_overheated(a_hot), .refuel_req(a_req)
`ifdef TRIP_ODOMETER_EN
        , .odometer(a_odo)
`endif
    );

    trip_status_gen #(.FUEL_CAP(8'd2), .BURN_PERIOD(1)) b (
        .clk(clk), .reset(reset), .start(start), .trip_dist(trip_dist),
        .keep_driving(keep_driving), .shut_off_computer(shut_off_computer),
        .cpu_temp(cpu_temp), .refuel_ack(refuel_ack),
        .arrived(b_arr), .gas_tank_empty(b_empty),
        .cpu_overheated(b_hot), .refuel_req(b_req)
`ifdef TRIP_ODOMETER_EN
        , .odometer(b_odo)
`endif
    );

    trip_status_gen #(.FUEL_CAP(8'd3), .BURN_PERIOD(1)) c (
        .clk(clk), .reset(reset), .start(start), .trip_dist(trip_dist),
        .keep_driving(keep_driving), .shut_off_computer(shut_off_computer),
        .cpu_temp(cpu_temp), .refuel_ack(refuel_ack),
        .arrived(c_arr), .gas_tank_empty(c_empty),
        .cpu_overheated(c_hot), .refuel_req(c_req)
`ifdef TRIP_ODOMETER_EN
        , .odometer(c_odo)
`endif
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] d);
        start = 1'b1;
        trip_dist = d;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        trip_dist = 16'd0;
        keep_driving = 1'b0;
        shut_off_computer = 1'b0;
        cpu_temp = 8'd50;
        refuel_ack = 1'b0;

        // Reset state
        do_reset();
        check("rst_arrived", 32'(a_arr), 0);
        check("rst_empty", 32'(a_empty), 0);
        check("rst_req", 32'(a_req), 0);
        check("rst_hot", 32'(a_hot), 0);
        check("rst_state", 32'(a.state_q), 32'(S_IDLE));
        check("rst_fuel", 32'(a.fuel_q), 255);
`ifdef TRIP_ODOMETER_EN
        check("rst_odo", a_odo, 0);
`endif

        // Basic trip of 5 on default instance
        keep_driving = 1'b1;
        do_start(16'd5);
        check("t5_state", 32'(a.state_q), 32'(S_DRIVING));
        tick(4);
        check("t5_rem_e5m", 32'(a.remaining_q), 1);
        check("t5_arr_e5m", 32'(a_arr), 0);
        tick();
        check("t5_arr_e5", 32'(a_arr), 0);
        tick();
        check("t5_arr_e6", 32'(a_arr), 1);
        check("t5_fuel", 32'(a.fuel_q), 254);
        check("t5_burn", 32'(a.burn_q), 1);
`ifdef TRIP_ODOMETER_EN
        check("t5_odo", a_odo, 5);
`endif

        // Small tank needing two refuels
        do_reset();
        do_start(16'd5);
        tick(2);
        check("b_empty", 32'(b_empty), 1);
        check("b_rem2", 32'(b.remaining_q), 3);
        tick();
        check("b_req", 32'(b_req), 1);
        tick(3);
        check("b_hold_rem", 32'(b.remaining_q), 3);
        check("b_hold_req", 32'(b_req), 1);
        refuel_ack = 1'b1;
        tick();
        refuel_ack = 1'b0;
        check("b_ack_state", 32'(b.state_q), 32'(S_DRIVING));
        check("b_ack_fuel", 32'(b.fuel_q), 2);
        check("b_ack_req", 32'(b_req), 0);
        tick(3);
        check("b_req2", 32'(b_req), 1);
        check("b_rem_r2", 32'(b.remaining_q), 1);
        refuel_ack = 1'b1;
        tick();
        refuel_ack = 1'b0;
        tick(2);
        check("b_arr", 32'(b_arr), 1);
        check("b_fuel_end", 32'(b.fuel_q), 1);

        // Fuel and distance run out together
        do_reset();
        do_start(16'd3);
        tick(3);
        check("c_empty_e3", 32'(c_empty), 1);
        check("c_arr_e3", 32'(c_arr), 0);
        tick();
        check("c_arr", 32'(c_arr), 1);
        check("c_empty", 32'(c_empty), 1);
        check("c_state", 32'(c.state_q), 32'(S_DONE));
        check("c_req", 32'(c_req), 0);

        // Overheat hysteresis
        keep_driving = 1'b0;
        cpu_temp = 8'd80; tick(); check("hot_80", 32'(a_hot), 0);
        cpu_temp = 8'd90; tick(); check("hot_90", 32'(a_hot), 1);
        cpu_temp = 8'd85; tick(); check("hot_85", 32'(a_hot), 1);
        cpu_temp = 8'd71; tick(); check("hot_71", 32'(a_hot), 1);
        cpu_temp = 8'd70; tick(); check("hot_70", 32'(a_hot), 0);
        cpu_temp = 8'd89; tick(); check("hot_89", 32'(a_hot), 0);

        // Shut-off freeze, then reset mid-refuel with competing inputs
        do_reset();
        keep_driving = 1'b1;
        do_start(16'd20);
        tick(3);
        check("so_rem", 32'(a.remaining_q), 17);
        check("so_b_req", 32'(b_req), 1);
        shut_off_computer = 1'b1;
        cpu_temp = 8'd95;
        tick(4);
        check("so_frozen", 32'(a.remaining_q), 17);
        check("so_burn", 32'(a.burn_q), 3);
        check("so_hot", 32'(a_hot), 1);
        shut_off_computer = 1'b0;
        tick(2);
        check("so_resume", 32'(a.remaining_q), 15);
        check("so_fuel", 32'(a.fuel_q), 254);
        reset = 1'b1;
        start = 1'b1;
        trip_dist = 16'd7;
        refuel_ack = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        refuel_ack = 1'b0;
        cpu_temp = 8'd50;
        check("rr_state", 32'(b.state_q), 32'(S_IDLE));
        check("rr_req", 32'(b_req), 0);
        check("rr_empty", 32'(b_empty), 0);
        check("rr_arr", 32'(b_arr), 0);
        check("rr_hot", 32'(b_hot), 0);
        check("rr_fuel", 32'(b.fuel_q), 2);
        check("rr_rem", 32'(a.remaining_q), 0);
        do_start(16'd0);
        check("zero_arr", 32'(a_arr), 1);
        check("zero_state", 32'(a.state_q), 32'(S_DONE));
        do_start(16'd2);
        check("restart_arr", 32'(a_arr), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/trip_status_gen.md
TRIP_STATUS_GEN -- requirements
Module: trip_status_gen

Interface
REQ-001 Parameter FUEL_CAP, default 8'd255, fuel units loaded at reset and on every refuel.
REQ-002 Parameter BURN_PERIOD, default 4, number of moving cycles per fuel unit consumed; legal range 1..255.
REQ-003 Parameter TEMP_HI, default 8'd90, overheat set threshold.
REQ-004 Parameter TEMP_LO, default 8'd70, overheat clear threshold; TEMP_LO < TEMP_HI.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  pulse; loads a new trip.
REQ-008 trip_dist  input  16  trip length in distance units, sampled when start is accepted.
REQ-009 keep_driving  input  1  driver request to move this cycle.
REQ-010 shut_off_computer  input  1  when 1, vehicle does not move.
REQ-011 cpu_temp  input  8  unsigned temperature sample, one per cycle.
REQ-012 refuel_ack  input  1  refuel station completion.
REQ-013 arrived  output  1  trip complete.
REQ-014 gas_tank_empty  output  1  fuel count is zero.
REQ-015 cpu_overheated  output  1  hysteretic overheat flag.
REQ-016 refuel_req  output  1  refuel request, held until acknowledged.

Function
REQ-017 The FSM SHALL have states IDLE, DRIVING, REFUEL and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL load remaining=trip_dist and clear arrived on the next edge; the next state SHALL be DONE if trip_dist==0, else DRIVING.
REQ-019 start SHALL be ignored in DRIVING and REFUEL.
REQ-020 In DRIVING, a cycle is "moving" iff keep_driving=1, shut_off_computer=0 and fuel>0; each moving cycle SHALL decrement remaining by 1 and increment the burn counter.
REQ-021 When the burn counter is at BURN_PERIOD-1 on a moving cycle, it SHALL wrap to 0 and fuel SHALL decrement by 1 on the same edge.
REQ-022 A non-moving cycle SHALL hold remaining, fuel and the burn counter.
REQ-023 When remaining reaches 0, the next state SHALL be DONE.
REQ-024 When fuel reaches 0 with remaining>0, the next state SHALL be REFUEL.
REQ-025 If remaining and fuel reach 0 on the same edge, the next state SHALL be DONE, and gas_tank_empty SHALL also be 1.
REQ-026 arrived SHALL equal (state==DONE), registered.
REQ-027 gas_tank_empty SHALL equal (fuel==0), from the fuel register, with no extra cycle of delay.
REQ-028 refuel_req SHALL be 1 throughout REFUEL.
REQ-029 A refuel_ack=1 sampled in REFUEL SHALL, on that edge, set fuel=FUEL_CAP, clear the burn counter and return to DRIVING; refuel_ack outside REFUEL SHALL be ignored.
REQ-030 cpu_overheated SHALL set on the edge after cpu_temp>=TEMP_HI and clear on the edge after cpu_temp<=TEMP_LO; values in between SHALL hold it.
REQ-031 cpu_overheated SHALL be independent of FSM state.

Reset
REQ-032 Reset SHALL apply the following on the next edge, regardless of state (including mid-trip and mid-refuel): state=IDLE, remaining=0, fuel=FUEL_CAP, burn counter=0, arrived=0, gas_tank_empty=0, refuel_req=0, cpu_overheated=0.
REQ-033 Reset SHALL take priority over start and refuel_ack.

Configuration
REQ-034 With macro TRIP_ODOMETER_EN defined, the block SHALL add output odometer[31:0], which counts moving cycles since reset, wraps at 2^32 and is not cleared by start.
REQ-035 Without TRIP_ODOMETER_EN, the odometer port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-036 Shared package trip_pkg SHALL hold the FSM state enum and the default values of FUEL_CAP, BURN_PERIOD, TEMP_HI and TEMP_LO.
REQ-037 The overheat logic SHALL be the sub-module temp_hysteresis, with parameters TEMP_HI and TEMP_LO, inputs clk, reset and cpu_temp, and output cpu_overheated.

Verification
REQ-038 Reset; start with trip_dist=5 and keep_driving=1 constant -> arrived=1 exactly 6 edges after start, and fuel=254 with BURN_PERIOD=4.
REQ-039 FUEL_CAP=2, BURN_PERIOD=1, trip_dist=5, keep_driving=1 -> gas_tank_empty=1 and refuel_req=1 after 2 moving cycles; hold refuel_ack=0 for 3 cycles -> no movement; refuel_ack=1 -> DRIVING, fuel=2, and arrived after 3 further moving cycles.
REQ-040 FUEL_CAP=3, BURN_PERIOD=1, trip_dist=3 -> arrived=1 and gas_tank_empty=1 together, state DONE, refuel_req=0.
REQ-041 cpu_temp sequence 80, 90, 85, 71, 70, 89 -> cpu_overheated 0, 0, 1, 1, 1, 0 (one-cycle lag).
REQ-042 Mid-trip, toggle shut_off_computer=1 for 4 cycles -> remaining is frozen; assert reset during REFUEL -> all outputs 0 next edge, state IDLE; start with trip_dist=0 -> arrived=1 next edge.
